// File: rtl/seven_seg_scan_bcd.sv
// 14-bit binary to 4-digit BCD (double-dabble, 15-cycle load-to-display) with a muxed digit/anode scanner.
// Loads are dropped while busy; the scanner free-runs and latches new digits only on slot changes.
module seven_seg_scan_bcd #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value_in,
  input  logic        value_valid,
  output logic        busy,
  output logic        overflow,
  output logic [3:0]  digit_out,
  output logic [3:0]  anode_n
);

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [13:0]   r_bin;
  logic [15:0]   r_bcd;
  logic [3:0]    r_cnt;
  logic [15:0]   r_d;
  logic          r_ovf;
  logic [CW-1:0] r_ref;
  logic [1:0]    r_p;
  logic [3:0]    r_anode_n;
  logic [3:0]    r_digit;

  logic          w_load;
  logic          w_commit;
  logic          w_wrap;
  logic [15:0]   w_adj;
  logic [1:0]    w_p_nxt;
  logic [15:0]   w_d_nxt;
  logic [3:0]    w_blank;
  logic [3:0]    w_digit_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (value_valid) begin
          w_load      = 1'b1;
          w_state_nxt = CONVERT;
        end
      end
      CONVERT: begin
        if (r_cnt == 4'd1) w_state_nxt = COMMIT;
      end
      COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_d   <= '0;
    end else begin
      if (w_load) begin
        r_bin <= (value_in > 14'd9999) ? 14'd9999 : value_in;
        r_bcd <= '0;
        r_cnt <= 4'd14;
        r_ovf <= (value_in > 14'd9999);
      end else if (r_state == CONVERT) begin
        {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
        r_cnt          <= r_cnt - 4'd1;
      end
      if (w_commit) r_d <= r_bcd;
    end
  end

  // Output registers look at next-cycle position and digits so a commit that
  // coincides with a slot change is shown immediately.
  assign w_wrap  = (r_ref == CW'(REFRESH_DIV - 1));
  assign w_p_nxt = r_p + 2'd1;
  assign w_d_nxt = w_commit ? r_bcd : r_d;

  always_comb begin
    w_blank[0]  = 1'b0;
    w_blank[3]  = BLANK_LZ && (w_d_nxt[15:12] == 4'd0);
    w_blank[2]  = BLANK_LZ && (w_d_nxt[15:8] == 8'd0);
    w_blank[1]  = BLANK_LZ && (w_d_nxt[15:4] == 12'd0);
    w_digit_nxt = w_blank[w_p_nxt] ? 4'hF : w_d_nxt[4*w_p_nxt +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref     <= '0;
      r_p       <= 2'd0;
      r_anode_n <= 4'b1110;
      r_digit   <= 4'h0;
    end else begin
      r_ref <= w_wrap ? '0 : r_ref + 1'b1;
      if (w_wrap) begin
        r_p       <= w_p_nxt;
        r_anode_n <= ~(4'b0001 << w_p_nxt);
        r_digit   <= w_digit_nxt;
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign overflow  = r_ovf;
  assign digit_out = r_digit;
  assign anode_n   = r_anode_n;

endmodule

// File: tb/tb_seven_seg_scan_bcd.sv
// Scoreboard bench: stimulus queues expected display contents, a monitor checks them at each busy fall.
`timescale 1ns/1ps
module tb_seven_seg_scan_bcd;

  typedef struct {
    int sat;
    bit ovf;
    bit aborted;
    bit chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        value_valid;
  logic [13:0] value_in;
  logic        busy_a, ovf_a, busy_b, ovf_b, busy_c, ovf_c;
  logic [3:0]  dig_a, an_a, dig_b, an_b, dig_c, an_c;

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   next_ok  = 0;
  int   mon_done = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seven_seg_scan_bcd #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_a (
    .clk(clk), .rst(rst), .value_in(value_in), .value_valid(value_valid),
    .busy(busy_a), .overflow(ovf_a), .digit_out(dig_a), .anode_n(an_a));
  seven_seg_scan_bcd #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_b (
    .clk(clk), .rst(rst), .value_in(value_in), .value_valid(value_valid),
    .busy(busy_b), .overflow(ovf_b), .digit_out(dig_b), .anode_n(an_b));
  seven_seg_scan_bcd #(.REFRESH_DIV(1), .BLANK_LZ(1'b1)) u_c (
    .clk(clk), .rst(rst), .value_in(value_in), .value_valid(value_valid),
    .busy(busy_c), .overflow(ovf_c), .digit_out(dig_c), .anode_n(an_c));

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Decimal digit k of the saturated value; leading positions blank when the value is below 10^k.
  function automatic int exp_digit(input int sat, input int k, input bit lz);
    int pw;
    pw = 10 ** k;
    if (lz && k > 0 && sat < pw) return 15;
    return (sat / pw) % 10;
  endfunction

  function automatic int pos_of(input logic [3:0] an);
    case (an)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v, input bit chk);
    value_in    = 14'(v);
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    if (cyc >= next_ok) begin
      sb_q.push_back('{(v > 9999) ? 9999 : v, (v > 9999), 1'b0, chk});
      next_ok = cyc + 16;
    end
  endtask

  task automatic reset_now();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    sb_q.push_back('{0, 1'b0, 1'b1, 1'b1});
    next_ok = cyc + 1;
  endtask

  task automatic wait_mon(input int target);
    int n;
    n = 0;
    while (mon_done < target && n < 400) begin
      tick();
      n++;
    end
    if (mon_done < target) begin
      n_checks++;
      n_err++;
      $display("FAIL mon_timeout: got %0d commits expected %0d", mon_done, target);
    end
  endtask

  task automatic frame_check(input int sat);
    int pa, pb, pc;
    int seen;
    seen = 0;
    repeat (17) @(negedge clk);
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      pa = pos_of(an_a);
      pb = pos_of(an_b);
      check("anode_onehot_a", int'(pa >= 0), 1);
      check("anode_onehot_b", int'(pb >= 0), 1);
      if (pa >= 0) begin
        seen = seen | (1 << pa);
        check("digit_lz1", int'(dig_a), exp_digit(sat, pa, 1'b1));
      end
      if (pb >= 0) check("digit_lz0", int'(dig_b), exp_digit(sat, pb, 1'b0));
      if (s < 4) begin
        pc = pos_of(an_c);
        check("anode_onehot_div1", int'(pc >= 0), 1);
        if (pc >= 0) check("digit_div1", int'(dig_c), exp_digit(sat, pc, 1'b1));
      end
    end
    check("scan_cover", seen, 15);
  endtask

  initial begin : monitor
    bit   prev;
    int   blen;
    exp_t e;
    prev = 1'b0;
    blen = 0;
    forever begin
      @(negedge clk);
      if (busy_a === 1'b1) blen++;
      if (prev && busy_a === 1'b0) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_commit: busy fell with nothing queued (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          if (!e.aborted) check("busy_len", blen, 15);
          check("overflow_a", int'(ovf_a), int'(e.ovf));
          check("overflow_b", int'(ovf_b), int'(e.ovf));
          if (e.chk) frame_check(e.sat);
        end
        mon_done++;
        blen = 0;
      end
      prev = (busy_a === 1'b1);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int m0;
    int v;
    rst         = 1'b1;
    value_valid = 1'b0;
    value_in    = '0;
    repeat (3) tick();
    check("rst_busy", int'(busy_a), 0);
    check("rst_overflow", int'(ovf_a), 0);
    check("rst_anode", int'(an_a), 4'b1110);
    check("rst_digit", int'(dig_a), 0);
    rst = 1'b0;
    for (int s = 0; s < 16; s++) begin
      check("scan_anode_a", int'(an_a), int'(~(4'b0001 << (s / 4)) & 4'hF));
      check("scan_digit_a", int'(dig_a), exp_digit(0, s / 4, 1'b1));
      check("scan_digit_b", int'(dig_b), exp_digit(0, s / 4, 1'b0));
      check("scan_anode_div1", int'(an_c), int'(~(4'b0001 << (s % 4)) & 4'hF));
      check("scan_digit_div1", int'(dig_c), exp_digit(0, s % 4, 1'b1));
      tick();
    end
    next_ok = cyc;

    m0 = mon_done; drive(1234, 1'b1);  wait_mon(m0 + 1);
    m0 = mon_done; drive(12000, 1'b1); wait_mon(m0 + 1);
    m0 = mon_done; drive(7, 1'b1);     wait_mon(m0 + 1);

    m0 = mon_done;
    drive(42, 1'b1);
    repeat (2) tick();
    drive(8888, 1'b1);
    repeat (6) tick();
    drive(8888, 1'b1);
    wait_mon(m0 + 1);

    m0 = mon_done;
    drive(9999, 1'b1);
    repeat (6) tick();
    reset_now();
    wait_mon(m0 + 1);
    m0 = mon_done; drive(305, 1'b1);   wait_mon(m0 + 1);
    m0 = mon_done; drive(1000, 1'b1);  wait_mon(m0 + 1);
    m0 = mon_done; drive(10000, 1'b1); wait_mon(m0 + 1);
    m0 = mon_done; drive(0, 1'b1);     wait_mon(m0 + 1);
    m0 = mon_done; drive(16383, 1'b1); wait_mon(m0 + 1);

    m0 = mon_done;
    drive(1111, 1'b0);
    repeat (15) tick();
    drive(5678, 1'b1);
    wait_mon(m0 + 2);

    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(9990, 16383);
        default: v = $urandom_range(0, 9999);
      endcase
      m0 = mon_done;
      drive(v, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 14)) tick();
        drive(int'($urandom_range(0, 16383)), 1'b1);
      end
      wait_mon(m0 + 1);
    end

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
